// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame master: FSM state type, legal
// parameter limits and a helper for sizing the chip-select index port.
package spi_pkg;

    localparam int SPI_MAX_DATA_W = 32;
    localparam int SPI_MAX_CS     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } spi_state_t;

    // A single chip select still needs a one-bit index port.
    function automatic int csIdxWidth(input int numCs);
        return (numCs > 1) ? $clog2(numCs) : 1;
    endfunction

endpackage

// File: rtl/spi_frame_master_shift.sv
// Parallel-load shift register shared by transmit and (optionally) receive.
// The head bit drives mosi; with SPI_RX_CAPTURE_EN defined the vacated end
// is filled from serial_i so the same register assembles the received word.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
)(
    input  logic             sclk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             serial_o
`ifdef SPI_RX_CAPTURE_EN
    ,
    input  logic             serial_i,
    output logic [WIDTH-1:0] data_o
`endif
);

    logic [WIDTH-1:0] shiftReg_q;
    logic [WIDTH-1:0] shiftReg_d;
    logic             fillBit;

`ifdef SPI_RX_CAPTURE_EN
    assign fillBit = serial_i;
    assign data_o  = shiftReg_q;
`else
    assign fillBit = 1'b0;
`endif

    assign serial_o = (MSB_FIRST != 0) ? shiftReg_q[WIDTH-1] : shiftReg_q[0];

    // Load wins over shift; shifting moves the next bit to the head end.
    always_comb begin
        shiftReg_d = shiftReg_q;
        if (load_i) begin
            shiftReg_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST != 0) begin
                shiftReg_d = {shiftReg_q[WIDTH-2:0], fillBit};
            end else begin
                shiftReg_d = {fillBit, shiftReg_q[WIDTH-1:1]};
            end
        end
    end

    // Register update with asynchronous active-low clear.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            shiftReg_q <= '0;
        end else begin
            shiftReg_q <= shiftReg_d;
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI frame master: sends one DATA_W-bit frame per accepted request to the
// selected chip select, then holds all selects high for GAP_CYC cycles.
// Optional receive capture is enabled by defining SPI_RX_CAPTURE_EN.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_CS    = 2,
    parameter int GAP_CYC   = 2,
    parameter int MSB_FIRST = 1
)(
    input  logic                           sclk,
    input  logic                           rst,
    input  logic                           tx_valid,
    input  logic [DATA_W-1:0]              tx_data,
    input  logic [csIdxWidth(NUM_CS)-1:0]  tx_cs,
    output logic                           tx_ready,
    output logic                           mosi,
    output logic [NUM_CS-1:0]              cs_n,
    output logic                           sck_en,
    output logic                           done,
    output logic                           cs_err
`ifdef SPI_RX_CAPTURE_EN
    ,
    input  logic                           miso,
    output logic [DATA_W-1:0]              rx_data
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_CYC - 1);

    spi_state_t        state_q,  state_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [3:0]        gapCnt_q, gapCnt_d;
    logic [NUM_CS-1:0] csN_q,    csN_d;
    logic              done_q,   done_d;
    logic              csErr_q,  csErr_d;
    logic              loadEn;
    logic              shiftEn;
    logic              serialOut;

    spi_shift_reg #(
        .WIDTH     (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) uShift (
        .sclk     (sclk),
        .rst      (rst),
        .load_i   (loadEn),
        .shift_i  (shiftEn),
        .data_i   (tx_data),
        .serial_o (serialOut)
`ifdef SPI_RX_CAPTURE_EN
        ,
        .serial_i (miso),
        .data_o   (rx_data)
`endif
    );

    // Frame sequencing: accept in IDLE, count bits in SHIFT, hold selects high in GAP.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        gapCnt_d = gapCnt_q;
        csN_d    = csN_q;
        done_d   = 1'b0;
        csErr_d  = 1'b0;
        loadEn   = 1'b0;
        shiftEn  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    loadEn   = 1'b1;
                    state_d  = ST_SHIFT;
                    bitCnt_d = '0;
                    csN_d    = '1;
                    for (int i = 0; i < NUM_CS; i++) begin
                        if (int'(tx_cs) == i) begin
                            csN_d[i] = 1'b0;
                        end
                    end
                    csErr_d = (int'(tx_cs) >= NUM_CS);
                end
            end
            ST_SHIFT: begin
                shiftEn = 1'b1;
                if (bitCnt_q == LAST_BIT) begin
                    csN_d    = '1;
                    done_d   = 1'b1;
                    gapCnt_d = '0;
                    state_d  = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gapCnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                csN_d   = '1;
            end
        endcase
    end

    // State registers; reset releases every select at once, killing any frame in flight.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= '0;
            gapCnt_q <= '0;
            csN_q    <= '1;
            done_q   <= 1'b0;
            csErr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            gapCnt_q <= gapCnt_d;
            csN_q    <= csN_d;
            done_q   <= done_d;
            csErr_q  <= csErr_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign sck_en   = (state_q == ST_SHIFT);
    assign mosi     = (state_q == ST_SHIFT) && serialOut;
    assign cs_n     = csN_q;
    assign done     = done_q;
    assign cs_err   = csErr_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master. Instance A uses default parameters;
// instance B is 12-bit, LSB-first, three selects and no inter-frame gap.
// Receive checks are compiled in only when SPI_RX_CAPTURE_EN is defined.
module tb_spi_frame_master;

    logic        sclk = 1'b0;
    logic        rst;

    logic        txValidA, txReadyA, mosiA, sckEnA, doneA, csErrA;
    logic [7:0]  txDataA;
    logic [0:0]  txCsA;
    logic [1:0]  csnA;

    logic        txValidB, txReadyB, mosiB, sckEnB, doneB, csErrB;
    logic [11:0] txDataB;
    logic [1:0]  txCsB;
    logic [2:0]  csnB;

`ifdef SPI_RX_CAPTURE_EN
    logic [7:0]  rxDataA;
    logic [11:0] rxDataB;
`endif

    int total = 0;
    int bad   = 0;

    always #5 sclk = ~sclk;

    spi_frame_master dutA (
        .sclk     (sclk),
        .rst      (rst),
        .tx_valid (txValidA),
        .tx_data  (txDataA),
        .tx_cs    (txCsA),
        .tx_ready (txReadyA),
        .mosi     (mosiA),
        .cs_n     (csnA),
        .sck_en   (sckEnA),
        .done     (doneA),
        .cs_err   (csErrA)
`ifdef SPI_RX_CAPTURE_EN
        ,
        .miso     (mosiA),
        .rx_data  (rxDataA)
`endif
    );

    spi_frame_master #(
        .DATA_W    (12),
        .NUM_CS    (3),
        .GAP_CYC   (0),
        .MSB_FIRST (0)
    ) dutB (
        .sclk     (sclk),
        .rst      (rst),
        .tx_valid (txValidB),
        .tx_data  (txDataB),
        .tx_cs    (txCsB),
        .tx_ready (txReadyB),
        .mosi     (mosiB),
        .cs_n     (csnB),
        .sck_en   (sckEnB),
        .done     (doneB),
        .cs_err   (csErrB)
`ifdef SPI_RX_CAPTURE_EN
        ,
        .miso     (1'b0),
        .rx_data  (rxDataB)
`endif
    );

    // Observers that pick instance A (s == 0) or B (s == 1).
    function automatic logic [31:0] csnOf(input int s);
        return (s == 0) ? {30'd0, csnA} : {29'd0, csnB};
    endfunction
    function automatic logic mosiOf(input int s);
        return (s == 0) ? mosiA : mosiB;
    endfunction
    function automatic logic doneOf(input int s);
        return (s == 0) ? doneA : doneB;
    endfunction
    function automatic logic readyOf(input int s);
        return (s == 0) ? txReadyA : txReadyB;
    endfunction
    function automatic logic sckEnOf(input int s);
        return (s == 0) ? sckEnA : sckEnB;
    endfunction
    function automatic logic [31:0] allHighOf(input int s);
        return (s == 0) ? 32'h3 : 32'h7;
    endfunction

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge, then scramble inputs to prove capture at E0.
    task automatic applyStimulus(input int s, input logic [31:0] data, input logic [1:0] cs);
        if (s == 0) begin
            txValidA = 1'b1; txDataA = data[7:0]; txCsA = cs[0:0];
        end else begin
            txValidB = 1'b1; txDataB = data[11:0]; txCsB = cs;
        end
        tick();
        if (s == 0) begin
            txValidA = 1'b0; txDataA = ~data[7:0]; txCsA = ~cs[0:0];
        end else begin
            txValidB = 1'b0; txDataB = ~data[11:0]; txCsB = 2'd0;
        end
    endtask

    // Called just after E0; seq lists mosi bits in wire order, first bit leftmost.
    task automatic runFrame(input int s, input logic [31:0] seq, input int len,
                            input logic [31:0] expCsn, input string tag);
        for (int i = 0; i < len; i++) begin
            checkOutput($sformatf("%s csn bit%0d", tag, i), csnOf(s), expCsn);
            checkOutput($sformatf("%s mosi bit%0d", tag, i), {31'd0, mosiOf(s)}, {31'd0, seq[len-1-i]});
            checkOutput($sformatf("%s done early bit%0d", tag, i), {31'd0, doneOf(s)}, 32'd0);
            tick();
        end
        checkOutput({tag, " done"}, {31'd0, doneOf(s)}, 32'd1);
        checkOutput({tag, " csn end"}, csnOf(s), allHighOf(s));
        checkOutput({tag, " sck_en end"}, {31'd0, sckEnOf(s)}, 32'd0);
        checkOutput({tag, " mosi end"}, {31'd0, mosiOf(s)}, 32'd0);
    endtask

    task automatic waitReady(input int s, input string tag);
        int n = 0;
        while (!readyOf(s) && n < 40) begin
            n++;
            tick();
        end
        checkOutput({tag, " ready"}, {31'd0, readyOf(s)}, 32'd1);
    endtask

    // Held tx_valid to select 1: gap counts cycles with selects high and ready low.
    task automatic backToBack(input int s, input int len, input int expGap, input string tag);
        int n;
        int gap;
        int idle;
        logic doneSeen;
        logic [31:0] target;
        target = (s == 0) ? 32'h1 : 32'h5;
        if (s == 0) begin
            txValidA = 1'b1; txCsA = 1'b1; txDataA = 8'hA5;
        end else begin
            txValidB = 1'b1; txCsB = 2'd1; txDataB = 12'hA5A;
        end
        tick();
        n = 0;
        while (csnOf(s) == target && n < 40) begin n++; tick(); end
        checkOutput({tag, " frame1 len"}, n, len);
        doneSeen = doneOf(s);
        gap = 0; idle = 0; n = 0;
        while (csnOf(s) == allHighOf(s) && n < 40) begin
            if (readyOf(s)) idle++; else gap++;
            n++;
            tick();
        end
        if (s == 0) txValidA = 1'b0; else txValidB = 1'b0;
        checkOutput({tag, " done1"}, {31'd0, doneSeen}, 32'd1);
        checkOutput({tag, " gap cycles"}, gap, expGap);
        checkOutput({tag, " accept cycles"}, idle, 32'd1);
        n = 0;
        while (csnOf(s) == target && n < 40) begin n++; tick(); end
        checkOutput({tag, " frame2 len"}, n, len);
        checkOutput({tag, " done2"}, {31'd0, doneOf(s)}, 32'd1);
        for (int i = 0; i < 20; i++) tick();
        checkOutput({tag, " no third frame"}, csnOf(s), allHighOf(s));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        txValidA = 1'b0; txDataA = 8'd0;  txCsA = 1'b0;
        txValidB = 1'b0; txDataB = 12'd0; txCsB = 2'd0;
        #12;
        checkOutput("reset A ready",  {31'd0, txReadyA}, 32'd1);
        checkOutput("reset A csn",    {30'd0, csnA}, 32'h3);
        checkOutput("reset A mosi",   {31'd0, mosiA}, 32'd0);
        checkOutput("reset A sck_en", {31'd0, sckEnA}, 32'd0);
        checkOutput("reset A done",   {31'd0, doneA}, 32'd0);
        checkOutput("reset A cs_err", {31'd0, csErrA}, 32'd0);
        checkOutput("reset B csn",    {29'd0, csnB}, 32'h7);
        checkOutput("reset B ready",  {31'd0, txReadyB}, 32'd1);
`ifdef SPI_RX_CAPTURE_EN
        checkOutput("reset A rx_data", {24'd0, rxDataA}, 32'd0);
        checkOutput("reset B rx_data", {20'd0, rxDataB}, 32'd0);
`endif
        rst = 1'b1;
        tick();

        $display("[TB] frame 0x92 to select 0");
        applyStimulus(0, 32'h92, 2'd0);
        checkOutput("A92 sck_en at E0", {31'd0, sckEnA}, 32'd1);
        checkOutput("A92 ready at E0",  {31'd0, txReadyA}, 32'd0);
        runFrame(0, 32'h92, 8, 32'h2, "A92");
        tick();
        checkOutput("A92 gap1 ready", {31'd0, txReadyA}, 32'd0);
        checkOutput("A92 gap1 done",  {31'd0, doneA}, 32'd0);
        tick();
        checkOutput("A92 ready after gap", {31'd0, txReadyA}, 32'd1);

        $display("[TB] frame 0x3C to select 1");
        applyStimulus(0, 32'h3C, 2'd1);
        runFrame(0, 32'h3C, 8, 32'h1, "A3C");
`ifdef SPI_RX_CAPTURE_EN
        checkOutput("A3C rx_data", {24'd0, rxDataA}, 32'h3C);
        tick();
        checkOutput("A3C rx_data held", {24'd0, rxDataA}, 32'h3C);
`endif
        waitReady(0, "A3C");

        $display("[TB] back-to-back on A");
        backToBack(0, 8, 2, "A b2b");

        $display("[TB] reset during bit 4");
        applyStimulus(0, 32'hC3, 2'd1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("rst pre csn",  {30'd0, csnA}, 32'h1);
        checkOutput("rst pre mosi", {31'd0, mosiA}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst async csn",   {30'd0, csnA}, 32'h3);
        checkOutput("rst async sck",   {31'd0, sckEnA}, 32'd0);
        checkOutput("rst async ready", {31'd0, txReadyA}, 32'd1);
        tick();
        checkOutput("rst hold done", {31'd0, doneA}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("rst no done %0d", i), {31'd0, doneA}, 32'd0);
        end
        applyStimulus(0, 32'h5A, 2'd0);
        runFrame(0, 32'h5A, 8, 32'h2, "A5A");
        waitReady(0, "A5A");

        $display("[TB] LSB-first 12-bit frame on B");
        applyStimulus(1, 32'hA53, 2'd2);
        runFrame(1, 32'b1100_1010_0101, 12, 32'h3, "BA53");
        checkOutput("BA53 ready at done", {31'd0, txReadyB}, 32'd1);
        tick();

        $display("[TB] out-of-range select on B");
        applyStimulus(1, 32'h0F0, 2'd3);
        checkOutput("Boob cs_err",  {31'd0, csErrB}, 32'd1);
        checkOutput("Boob sck_en",  {31'd0, sckEnB}, 32'd1);
        checkOutput("Boob ready",   {31'd0, txReadyB}, 32'd0);
        checkOutput("Boob csn E0",  {29'd0, csnB}, 32'h7);
        for (int i = 1; i < 12; i++) begin
            tick();
            checkOutput($sformatf("Boob csn %0d", i), {29'd0, csnB}, 32'h7);
            checkOutput($sformatf("Boob done early %0d", i), {31'd0, doneB}, 32'd0);
            checkOutput($sformatf("Boob cs_err clr %0d", i), {31'd0, csErrB}, 32'd0);
        end
        tick();
        checkOutput("Boob done", {31'd0, doneB}, 32'd1);
        checkOutput("Boob csn end", {29'd0, csnB}, 32'h7);
        tick();

        $display("[TB] back-to-back on B");
        backToBack(1, 12, 0, "B b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
